// File: rtl/light_zone_buffer_pkg.sv
// Shared types and constants for the light zone buffer.
// Holds the FSM state enum, Q1.8 gain constants, widths and the gain helper.
package light_zone_buffer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_e;

   localparam int GAIN_ONE   = 256;
   localparam int ZONE_IDX_W = 9;
   localparam int LIGHT_W    = 16;
   localparam int GAIN_W     = 9;
   localparam int PROD_W     = 25;

   // min(gmin + lux/4, 1.0) in Q1.8, evaluated at 17 bits
   function automatic logic [GAIN_W-1:0] gain_calc(
      input logic [LIGHT_W-1:0] lux_v,
      input logic [16:0]        gmin
   );
      logic [16:0] sum;
      sum = gmin + (17'(lux_v) >> 2);
      return GAIN_W'((sum > 17'(GAIN_ONE)) ? 17'(GAIN_ONE) : sum);
   endfunction

endpackage

// File: rtl/zone_bank_ram.sv
// One zone bank: simple dual-port 512x16 RAM with registered read.
// Ports: clk_i, write we_i/waddr_i/wdata_i, read re_i/raddr_i -> rdata_o.
module zone_bank_ram
   import light_zone_buffer_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [ZONE_IDX_W-1:0] waddr_i,
   input  logic [LIGHT_W-1:0]    wdata_i,
   input  logic                  re_i,
   input  logic [ZONE_IDX_W-1:0] raddr_i,
   output logic [LIGHT_W-1:0]    rdata_o
);

   logic [LIGHT_W-1:0] mem_q [0:(1<<ZONE_IDX_W)-1];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_o <= mem_q[raddr_i];
      end
   end

endmodule

// File: rtl/light_zone_buffer.sv
// Ambient-gain scaling and double-buffered frame store for MiniLED zones.
// Ports: producer wr_*/frame_done, ambient lux_*, consumer rd_*, status outputs.
module light_zone_buffer
   import light_zone_buffer_pkg::*;
#(
   parameter int ZONES    = 288,
   parameter int GAIN_MIN = 32
) (
   input  logic                  I_clk,
   input  logic                  I_rst_n,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [ZONE_IDX_W-1:0] wr_index,
   input  logic [LIGHT_W-1:0]    wr_light,
   input  logic                  frame_done,
   input  logic                  lux_valid,
   input  logic [LIGHT_W-1:0]    lux,
   input  logic                  rd_en,
   input  logic [ZONE_IDX_W-1:0] rd_index,
   output logic                  rd_valid,
   output logic [LIGHT_W-1:0]    rd_data,
   output logic                  frame_ready,
   output logic [7:0]            overrun_cnt,
   output logic                  idx_err
);

   localparam logic [ZONE_IDX_W:0] ZONES_L = (ZONE_IDX_W+1)'(ZONES);

   // async assert, clock-synchronised release
   logic [1:0] rst_sync_q;
   logic       rst_n_s;

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n_s = rst_sync_q[1];

   state_e state_q, state_d;
   logic   drain_q, drain_d;
   logic   swap;
   logic   rd_bank_q;
   logic   frame_ready_q;
   logic [7:0] overrun_q;

   logic [GAIN_W-1:0] gain_next_q;
   logic [GAIN_W-1:0] gain_active_q;

   logic                  s1_valid_q;
   logic [ZONE_IDX_W-1:0] s1_idx_q;
   logic [LIGHT_W-1:0]    s1_light_q;
   logic                  idx_err_q;

   logic wr_acc;
   logic wr_in_range;
   logic rd_in_range;

   assign wr_acc      = wr_valid && wr_ready;
   assign wr_in_range = {1'b0, wr_index} < ZONES_L;
   assign rd_in_range = {1'b0, rd_index} < ZONES_L;

   // drain_q marks the second DRAIN cycle; the write pipeline is
   // always empty by then, which fixes frame_done->frame_ready at 3
   always_comb begin
      state_d  = state_q;
      drain_d  = 1'b0;
      wr_ready = 1'b0;
      swap     = 1'b0;
      unique case (state_q)
         IDLE: begin
            wr_ready = 1'b1;
            if (frame_done) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            drain_d = 1'b1;
            if (drain_q && !s1_valid_q) begin
               swap    = 1'b1;
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge I_clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         state_q       <= IDLE;
         drain_q       <= 1'b0;
         rd_bank_q     <= 1'b0;
         frame_ready_q <= 1'b0;
         overrun_q     <= 8'd0;
         gain_next_q   <= GAIN_W'(GAIN_ONE);
         gain_active_q <= GAIN_W'(GAIN_ONE);
      end else begin
         state_q       <= state_d;
         drain_q       <= drain_d;
         rd_bank_q     <= rd_bank_q ^ swap;
         frame_ready_q <= swap;
         if (frame_done && state_q == DRAIN && overrun_q != 8'hFF) begin
            overrun_q <= overrun_q + 8'd1;
         end
         if (lux_valid) begin
            gain_next_q <= gain_calc(lux, 17'(GAIN_MIN));
         end
         if (swap) begin
            gain_active_q <= gain_next_q;
         end
      end
   end

   // write stage 1: register accepted in-range samples
   always_ff @(posedge I_clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         s1_valid_q <= 1'b0;
         s1_idx_q   <= '0;
         s1_light_q <= '0;
         idx_err_q  <= 1'b0;
      end else begin
         s1_valid_q <= wr_acc && wr_in_range;
         if (wr_acc) begin
            s1_idx_q   <= wr_index;
            s1_light_q <= wr_light;
         end
         if (wr_acc && !wr_in_range) begin
            idx_err_q <= 1'b1;
         end
      end
   end

   // write stage 2: scale and store; gain <= 1.0 so bits [23:8] hold it
   logic [PROD_W-1:0]  prod;
   logic [LIGHT_W-1:0] wr_word;
   logic               unused_prod;

   assign prod        = PROD_W'(s1_light_q) * PROD_W'(gain_active_q);
   assign wr_word     = prod[23:8];
   assign unused_prod = ^{prod[24], prod[7:0]};

   logic we0, we1, re0, re1;
   logic [LIGHT_W-1:0] q0, q1;

   // write bank is always the complement of the read bank
   assign we0 = s1_valid_q && rd_bank_q;
   assign we1 = s1_valid_q && !rd_bank_q;
   assign re0 = rd_en && rd_in_range && !rd_bank_q;
   assign re1 = rd_en && rd_in_range && rd_bank_q;

   zone_bank_ram u_bank0 (
      .clk_i   (I_clk),
      .we_i    (we0),
      .waddr_i (s1_idx_q),
      .wdata_i (wr_word),
      .re_i    (re0),
      .raddr_i (rd_index),
      .rdata_o (q0)
   );

   zone_bank_ram u_bank1 (
      .clk_i   (I_clk),
      .we_i    (we1),
      .waddr_i (s1_idx_q),
      .wdata_i (wr_word),
      .re_i    (re1),
      .raddr_i (rd_index),
      .rdata_o (q1)
   );

   // read bank captured at rd_en so a swap in flight cannot redirect it
   logic                  r1_valid_q;
   logic                  r1_bank_q;
   logic                  r1_ok_q;
   logic                  rd_valid_q;
   logic [LIGHT_W-1:0]    rd_data_q;

   always_ff @(posedge I_clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         r1_valid_q <= 1'b0;
         r1_bank_q  <= 1'b0;
         r1_ok_q    <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         r1_valid_q <= rd_en;
         r1_bank_q  <= rd_bank_q;
         r1_ok_q    <= rd_in_range;
         rd_valid_q <= r1_valid_q;
         if (r1_valid_q) begin
            rd_data_q <= r1_ok_q ? (r1_bank_q ? q1 : q0) : '0;
         end
      end
   end

   assign rd_valid    = rd_valid_q;
   assign rd_data     = rd_data_q;
   assign frame_ready = frame_ready_q;
   assign overrun_cnt = overrun_q;
   assign idx_err     = idx_err_q;

endmodule
